snoop_loader: RTL and testbench



---
 rtl/snoop_loader_pkg.sv | 34 +++
 rtl/snoop_loader.sv | 196 +++++++++++++++++++
 tb/tb_snoop_loader.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/snoop_loader_pkg.sv
// Shared opcode constants, state encoding and helpers for the snoop_loader host command engine.
// Optional checksum command is compiled in with SNOOP_LOADER_CKSUM_EN.
package snoop_loader_pkg;

  localparam logic [1:0] OP_SETADDR = 2'b00;
  localparam logic [1:0] OP_WRMEM   = 2'b01;
  localparam logic [1:0] OP_WRPRG   = 2'b10;
  localparam logic [1:0] OP_EXT     = 2'b11;

  // Sub-decodes of the EXT group: READ uses bit 5, the others bits 5:4.
  localparam logic       EXT_READ   = 1'b0;
  localparam logic [1:0] EXT_RSTCTL = 2'b10;
  localparam logic [1:0] EXT_CKSUM  = 2'b11;

  localparam int unsigned STATE_W = 3;
  localparam logic [STATE_W-1:0] S_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] S_ADDR    = 3'd1;
  localparam logic [STATE_W-1:0] S_WDATA   = 3'd2;
  localparam logic [STATE_W-1:0] S_RD_WAIT = 3'd3;
  localparam logic [STATE_W-1:0] S_RD_SEND = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = S_IDLE,
    ST_ADDR    = S_ADDR,
    ST_WDATA   = S_WDATA,
    ST_RD_WAIT = S_RD_WAIT,
    ST_RD_SEND = S_RD_SEND
  } state_e;

  function automatic logic accepts_rx(input state_e s);
    return (s == ST_IDLE) || (s == ST_ADDR) || (s == ST_WDATA);
  endfunction

endpackage

// File: rtl/snoop_loader.sv
// Byte-command engine driving the discus snoop port: address set, data/program writes, readback, CPU reset control.
// Define SNOOP_LOADER_CKSUM_EN to enable the running write checksum returned by the 1111xxxx command.
module snoop_loader
  import snoop_loader_pkg::*;
#(
  parameter logic RESET_ON_BOOT = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] snoopa,
  output logic [7:0] snoopd,
  output logic       snoopm,
  output logic       snoopp,
  input  logic [7:0] snoopq,
  output logic       cpu_reset
);

  state_e     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [5:0] cnt_q, cnt_d;
  logic       prg_q, prg_d;
  logic       ck_q, ck_d;
  logic [7:0] snoopd_q, snoopd_d;
  logic       snoopm_q, snoopm_d;
  logic       snoopp_q, snoopp_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;
  logic       cpu_reset_q, cpu_reset_d;
  logic       rx_ready_q, rx_ready_d;
  logic       rx_fire_s;
`ifdef SNOOP_LOADER_CKSUM_EN
  logic [7:0] sum_q, sum_d;
`endif

  assign rx_fire_s = rx_valid && rx_ready_q;

  // Command decode, burst sequencing and next-state for every register.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prg_d       = prg_q;
    ck_d        = ck_q;
    snoopd_d    = snoopd_q;
    snoopm_d    = 1'b0;
    snoopp_d    = 1'b0;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    cpu_reset_d = cpu_reset_q;
    // A write strobe in flight advances the address at the end of its cycle.
    addr_d      = addr_q + {7'd0, (snoopm_q | snoopp_q)};
`ifdef SNOOP_LOADER_CKSUM_EN
    sum_d       = sum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rx_fire_s) begin
          case (rx_data[7:6])
            OP_SETADDR: state_d = ST_ADDR;
            OP_WRMEM, OP_WRPRG: begin
              cnt_d   = rx_data[5:0];
              prg_d   = (rx_data[7:6] == OP_WRPRG);
              state_d = ST_WDATA;
            end
            OP_EXT: begin
              if (rx_data[5] == EXT_READ) begin
                cnt_d   = {1'b0, rx_data[4:0]};
                state_d = ST_RD_WAIT;
              end else if (rx_data[5:4] == EXT_RSTCTL) begin
                cpu_reset_d = rx_data[0];
              end else begin
`ifdef SNOOP_LOADER_CKSUM_EN
                tx_data_d  = sum_q;
                tx_valid_d = 1'b1;
                sum_d      = 8'h00;
                ck_d       = 1'b1;
                cnt_d      = 6'd0;
                state_d    = ST_RD_SEND;
`else
                state_d = ST_IDLE;
`endif
              end
            end
            default: state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (rx_fire_s) begin
          addr_d  = rx_data;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_WDATA: begin
        if (rx_fire_s) begin
          snoopd_d = rx_data;
          snoopm_d = !prg_q;
          snoopp_d = prg_q;
`ifdef SNOOP_LOADER_CKSUM_EN
          sum_d    = sum_q + rx_data;
`endif
          if (cnt_q == 6'd0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end else begin
          state_d = ST_WDATA;
        end
      end
      ST_RD_WAIT: begin
        tx_data_d  = snoopq;
        tx_valid_d = 1'b1;
        state_d    = ST_RD_SEND;
      end
      ST_RD_SEND: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          ck_d       = 1'b0;
          // The checksum byte is not a memory read, so it leaves addr alone.
          if (!ck_q) begin
            addr_d = addr_q + 8'd1;
          end else begin
            addr_d = addr_q;
          end
          if ((cnt_q == 6'd0) || ck_q) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d   = cnt_q - 6'd1;
            state_d = ST_RD_WAIT;
          end
        end else begin
          state_d = ST_RD_SEND;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    rx_ready_d = accepts_rx(state_d);
  end

  // State and output registers; reset also kills any strobe in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= 8'h00;
      cnt_q       <= 6'd0;
      prg_q       <= 1'b0;
      ck_q        <= 1'b0;
      snoopd_q    <= 8'h00;
      snoopm_q    <= 1'b0;
      snoopp_q    <= 1'b0;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      cpu_reset_q <= RESET_ON_BOOT;
      rx_ready_q  <= 1'b1;
`ifdef SNOOP_LOADER_CKSUM_EN
      sum_q       <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      prg_q       <= prg_d;
      ck_q        <= ck_d;
      snoopd_q    <= snoopd_d;
      snoopm_q    <= snoopm_d;
      snoopp_q    <= snoopp_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      cpu_reset_q <= cpu_reset_d;
      rx_ready_q  <= rx_ready_d;
`ifdef SNOOP_LOADER_CKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign rx_ready  = rx_ready_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign snoopa    = addr_q;
  assign snoopd    = snoopd_q;
  assign snoopm    = snoopm_q;
  assign snoopp    = snoopp_q;
  assign cpu_reset = cpu_reset_q;

endmodule

// File: tb/tb_snoop_loader.sv
// Directed bench for snoop_loader with a small discus data-memory model on the snoop port.
// Honours SNOOP_LOADER_CKSUM_EN to pick the checksum-command expectations.
module tb_snoop_loader;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] snoopa;
  logic [7:0] snoopd;
  logic       snoopm;
  logic       snoopp;
  logic [7:0] snoopq;
  logic       cpu_reset;

  int total = 0;
  int bad   = 0;
  logic [7:0] mem [256];
  logic [7:0] got;

  always #5 clk = ~clk;

  snoop_loader #(.RESET_ON_BOOT(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .snoopa(snoopa), .snoopd(snoopd), .snoopm(snoopm), .snoopp(snoopp),
    .snoopq(snoopq), .cpu_reset(cpu_reset)
  );

  // discus data memory: writes on the strobe edge, read register settles within the address cycle
  always @(posedge clk) if (snoopm) mem[snoopa] <= snoopd;
  always @(negedge clk) snoopq <= mem[snoopa];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a byte and return just after the edge that accepted it; rx_valid is left high.
  task automatic put(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 20) begin
      step();
      n++;
    end
    step();
    chk("put_accept_in_time", {7'd0, (n < 20)}, 8'h01);
  endtask

  // Wait for a tx byte (tx_ready must be high) and return just after its handshake edge.
  task automatic get(output logic [7:0] b);
    int n;
    n = 0;
    while (!tx_valid && n < 20) begin
      step();
      n++;
    end
    b = tx_data;
    step();
    chk("get_tx_in_time", {7'd0, (n < 20)}, 8'h01);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    step();
    chk("rst_rx_ready", {7'd0, rx_ready}, 8'h01);
    chk("rst_tx_valid", {7'd0, tx_valid}, 8'h00);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_snoopa", snoopa, 8'h00);
    chk("rst_snoopd", snoopd, 8'h00);
    chk("rst_strobes", {6'd0, snoopm, snoopp}, 8'h00);
    chk("rst_cpu_reset", {7'd0, cpu_reset}, 8'h01);

    // Reset request control
    put(8'hE0); rx_valid = 1'b0;
    chk("rstctl_release", {7'd0, cpu_reset}, 8'h00);
    put(8'hE1); rx_valid = 1'b0;
    chk("rstctl_hold", {7'd0, cpu_reset}, 8'h01);

    // Program-RAM burst, back to back
    put(8'h00); put(8'h10); put(8'h82);
    put(8'hAA);
    chk("prg0_strobes", {6'd0, snoopm, snoopp}, 8'h01);
    chk("prg0_addr", snoopa, 8'h10);
    chk("prg0_data", snoopd, 8'hAA);
    put(8'hBB);
    chk("prg1_strobes", {6'd0, snoopm, snoopp}, 8'h01);
    chk("prg1_addr", snoopa, 8'h11);
    chk("prg1_data", snoopd, 8'hBB);
    put(8'hCC);
    chk("prg2_strobes", {6'd0, snoopm, snoopp}, 8'h01);
    chk("prg2_addr", snoopa, 8'h12);
    chk("prg2_data", snoopd, 8'hCC);
    rx_valid = 1'b0;
    step();
    chk("prg_end_strobes", {6'd0, snoopm, snoopp}, 8'h00);
    chk("prg_end_addr", snoopa, 8'h13);

    // Data-memory burst across the address wrap
    put(8'h00); put(8'hFE); put(8'h42);
    put(8'h01);
    chk("mem0_strobes", {6'd0, snoopm, snoopp}, 8'h02);
    chk("mem0_addr", snoopa, 8'hFE);
    chk("mem0_data", snoopd, 8'h01);
    put(8'h02);
    chk("mem1_addr", snoopa, 8'hFF);
    chk("mem1_data", snoopd, 8'h02);
    put(8'h03);
    chk("mem2_strobes", {6'd0, snoopm, snoopp}, 8'h02);
    chk("mem2_addr_wrap", snoopa, 8'h00);
    chk("mem2_data", snoopd, 8'h03);
    rx_valid = 1'b0;
    step();
    chk("mem_end_strobes", {6'd0, snoopm, snoopp}, 8'h00);

    // Readback with a stalled host
    put(8'h00); put(8'hFE); put(8'hC2);
    rx_valid = 1'b0;
    chk("rd_wait_rx_ready", {7'd0, rx_ready}, 8'h00);
    chk("rd_wait_tx_valid", {7'd0, tx_valid}, 8'h00);
    step();
    chk("rd_first_valid", {7'd0, tx_valid}, 8'h01);
    chk("rd_first_data", tx_data, 8'h01);
    repeat (4) begin
      step();
      chk("rd_stall_valid", {7'd0, tx_valid}, 8'h01);
      chk("rd_stall_data", tx_data, 8'h01);
      chk("rd_stall_rx_ready", {7'd0, rx_ready}, 8'h00);
    end
    tx_ready = 1'b1;
    get(got);
    chk("rd_byte0", got, 8'h01);
    chk("rd_byte0_rx_ready", {7'd0, rx_ready}, 8'h00);
    get(got);
    chk("rd_byte1", got, 8'h02);
    chk("rd_byte1_rx_ready", {7'd0, rx_ready}, 8'h00);
    get(got);
    chk("rd_byte2", got, 8'h03);
    chk("rd_done_rx_ready", {7'd0, rx_ready}, 8'h01);
    chk("rd_done_tx_valid", {7'd0, tx_valid}, 8'h00);
    chk("rd_done_addr", snoopa, 8'h01);
    tx_ready = 1'b0;

    // Reset in the middle of a program burst
    put(8'h00); put(8'h20); put(8'h83); put(8'h11); put(8'h22);
    chk("midrst_strobe_before", {6'd0, snoopm, snoopp}, 8'h01);
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    #1;
    chk("midrst_strobe_async", {6'd0, snoopm, snoopp}, 8'h00);
    chk("midrst_addr", snoopa, 8'h00);
    #3 reset_n = 1'b1;
    put(8'h00);
    chk("midrst_no_data_strobe", {6'd0, snoopm, snoopp}, 8'h00);
    put(8'h30);
    rx_valid = 1'b0;
    chk("midrst_setaddr", snoopa, 8'h30);

`ifdef SNOOP_LOADER_CKSUM_EN
    put(8'h42); put(8'h80); put(8'h90); put(8'h05);
    rx_valid = 1'b0;
    step();
    put(8'hF0);
    rx_valid = 1'b0;
    chk("ck_rx_ready_busy", {7'd0, rx_ready}, 8'h00);
    tx_ready = 1'b1;
    get(got);
    chk("ck_sum", got, 8'h15);
    chk("ck_rx_ready_after", {7'd0, rx_ready}, 8'h01);
    chk("ck_addr_kept", snoopa, 8'h33);
    put(8'hF0);
    rx_valid = 1'b0;
    get(got);
    chk("ck_sum_cleared", got, 8'h00);
    tx_ready = 1'b0;
`else
    put(8'hF0);
    rx_valid = 1'b0;
    repeat (3) begin
      chk("ck_off_no_tx", {7'd0, tx_valid}, 8'h00);
      chk("ck_off_rx_ready", {7'd0, rx_ready}, 8'h01);
      step();
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
